// File: rtl/autoc_ctrl.sv
// rtl/autoc_ctrl.sv - autocorrelation sequencer: prime lag line, accumulate N products, hand off result
// Optional idle timeout abort enabled by defining AUTOC_CTRL_TIMEOUT_EN.
module autoc_ctrl #(
  parameter int BASE      = 0,
  parameter int CNT_WIDTH = 16,
  parameter int DELAY     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_stb,
  input  logic [7:0]                   set_addr,
  input  logic [31:0]                  set_data,
  output logic                         ddc_out_enable,
  input  logic                         ddc_out_strobe,
  output logic [$clog2(DELAY+1)-1:0]   lag,
  output logic                         acc_clr,
  output logic                         acc_en,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         busy,
`ifdef AUTOC_CTRL_TIMEOUT_EN
  output logic                         timeout,
`endif
  output logic                         overrun
);
  localparam int LW = $clog2(DELAY+1);
  localparam logic [7:0] ADDR_N    = 8'(BASE);
  localparam logic [7:0] ADDR_L    = 8'(BASE + 1);
  localparam logic [7:0] ADDR_CTRL = 8'(BASE + 2);

  typedef enum logic [1:0] {IDLE, PRIME, ACCUM, DUMP} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] n_reg, n_work, cnt;
  logic [LW-1:0]        l_reg, l_work;
  logic                 cont_reg, cont_work;
  logic                 go_q, abort_q;
  logic                 abort_now, go_accept;
  logic                 unused_ok;

  assign unused_ok = ^set_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg    <= CNT_WIDTH'(1);
      l_reg    <= LW'(1);
      cont_reg <= 1'b0;
      go_q     <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      go_q    <= 1'b0;
      abort_q <= 1'b0;
      if (set_stb) begin
        if (set_addr == ADDR_N)
          n_reg <= (set_data[CNT_WIDTH-1:0] == '0) ? CNT_WIDTH'(1) : set_data[CNT_WIDTH-1:0];
        if (set_addr == ADDR_L) begin
          if (set_data[7:0] == 8'd0)
            l_reg <= LW'(1);
          else if (int'(set_data[7:0]) > DELAY)
            l_reg <= LW'(DELAY);
          else
            l_reg <= set_data[LW-1:0];
        end
        if (set_addr == ADDR_CTRL) begin
          cont_reg <= set_data[1];
          abort_q  <= set_data[2];
          go_q     <= set_data[0] & ~set_data[2];
        end
      end
    end
  end

`ifdef AUTOC_CTRL_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout_hit;

  assign timeout_hit = ((state == PRIME) || (state == ACCUM)) && (idle_cnt == 16'hFFFF);
  assign abort_now   = abort_q | timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (timeout_hit)
        timeout <= 1'b1;
      else if (go_accept)
        timeout <= 1'b0;
      if (((state == PRIME) || (state == ACCUM)) && !ddc_out_strobe && !abort_now)
        idle_cnt <= idle_cnt + 16'd1;
      else
        idle_cnt <= '0;
    end
  end
`else
  assign abort_now = abort_q;
`endif

  assign go_accept = go_q && (state == IDLE) && !abort_now;
  assign busy      = (state != IDLE);
  assign lag       = busy ? l_work : l_reg;
  assign acc_en    = (state == ACCUM) && ddc_out_strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ddc_out_enable <= 1'b0;
      acc_clr        <= 1'b0;
      result_valid   <= 1'b0;
      overrun        <= 1'b0;
      cnt            <= '0;
      n_work         <= CNT_WIDTH'(1);
      l_work         <= LW'(1);
      cont_work      <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      if (abort_now) begin
        state          <= IDLE;
        ddc_out_enable <= 1'b0;
        result_valid   <= 1'b0;
        acc_clr        <= 1'b1;
        cnt            <= '0;
      end else begin
        case (state)
          IDLE: if (go_accept) begin
            state          <= PRIME;
            ddc_out_enable <= 1'b1;
            acc_clr        <= 1'b1;
            cnt            <= '0;
            n_work         <= n_reg;
            l_work         <= l_reg;
            cont_work      <= cont_reg;
            overrun        <= 1'b0;
          end
          PRIME: if (ddc_out_strobe) begin
            if (cnt == CNT_WIDTH'(l_work) - CNT_WIDTH'(1)) begin
              state <= ACCUM;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
          ACCUM: if (ddc_out_strobe) begin
            if (cnt == n_work - CNT_WIDTH'(1)) begin
              state          <= DUMP;
              result_valid   <= 1'b1;
              ddc_out_enable <= cont_work;
              cnt            <= '0;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
          DUMP: begin
            // Samples arriving while the result waits are lost; the lag line stays primed.
            if (ddc_out_strobe && cont_work)
              overrun <= 1'b1;
            if (result_ready) begin
              result_valid <= 1'b0;
              if (cont_work) begin
                state   <= ACCUM;
                acc_clr <= 1'b1;
              end else begin
                state          <= IDLE;
                ddc_out_enable <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/autoc_ctrl.md
Name: autoc_ctrl

Overview:
- Sequencer for the autocorrelation datapath: lag delay line, I/Q multipliers and 43-bit si/sq accumulators.
- Programmed over the settings bus.
- Gates the DDC, primes the delay line with L samples, then accumulates exactly N lagged products.
- Hands the result to the readout with a valid/ready handshake, single-shot or continuous.

Parameters:
- BASE, 0: settings-bus base address; registers at BASE+0..BASE+2.
- CNT_WIDTH, 16: width of the window-length and sample counters.
- DELAY, 8: maximum lag supported by the datapath delay line.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- ddc_out_enable  out  1  enables the DDC chain.
- ddc_out_strobe  in  1  high on a valid DDC sample.
- lag  out  $clog2(DELAY+1)  effective lag L driven to the datapath.
- acc_clr  out  1  one-cycle accumulator clear.
- acc_en  out  1  accumulate the current sample.
- result_valid  out  1  si/sq accumulators hold a finished window.
- result_ready  in  1  readout accepts the result.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: samples dropped in continuous mode.

Behaviour:
- Registers (write only; a write takes effect the next cycle):
  - BASE+0: N = set_data[CNT_WIDTH-1:0]; N=0 is treated as 1.
  - BASE+1: L = set_data[7:0]; 0 is treated as 1, values >DELAY clamp to DELAY.
  - BASE+2: bit0 go (self-clearing pulse), bit1 continuous, bit2 abort (pulse). A write with both go and abort: abort wins.
- N and L are captured into working copies when go is accepted. Register writes during a run affect only the next run.
- Reset values:
  - ddc_out_enable=0, acc_clr=0, acc_en=0, result_valid=0, busy=0, overrun=0.
  - lag=1, N reg=1, L reg=1, continuous=0, state=IDLE, counters=0.
- States:
  - IDLE: ddc_out_enable=0. go -> PRIME, with acc_clr=1 for the entry cycle.
  - PRIME: ddc_out_enable=1. Count L strobes without accumulating. On the L-th strobe -> ACCUM.
  - ACCUM: ddc_out_enable=1.
    - acc_en = ddc_out_strobe, combinational and same cycle as the sample. Asserted only in this state.
    - On the N-th strobe -> DUMP; result_valid is registered high the next cycle.
  - DUMP: result_valid=1 until the cycle result_valid && result_ready.
    - On handshake, single-shot -> IDLE.
    - On handshake, continuous -> ACCUM with acc_clr=1 that cycle. The delay line stays primed, so there is no re-prime.
    - ddc_out_enable stays 1 in continuous mode and is 0 in single-shot.
- Overrun (continuous mode):
  - Any strobe arriving in DUMP is discarded and sets overrun.
  - overrun is cleared only by rst or a go write.
- Boundaries:
  - A strobe on the same cycle as the ACCUM->DUMP transition cycle's successor belongs to DUMP.
  - A handshake and a strobe in the same cycle: the strobe is dropped (overrun set) and the next window starts clean.
  - abort in any state -> IDLE next cycle. result_valid drops; acc_clr is pulsed; overrun is kept.
  - go while busy is ignored.
  - rst mid-run -> all reset values next edge; no result is emitted.
  - The counter never wraps: it compares against N-1 and reloads on each window.
- Latency:
  - go write to ddc_out_enable=1: 2 cycles (write registered, then state registered).
  - Last ACCUM strobe to result_valid: 1 cycle.

Optional Feature:
- Macro: AUTOC_CTRL_TIMEOUT_EN.
- When defined:
  - A 16-bit idle counter runs in PRIME/ACCUM and resets on each ddc_out_strobe.
  - When it reaches 65535, the FSM aborts to IDLE exactly as for an abort write, and sets a sticky output port timeout (cleared by rst or go).
- When not defined: no counter, no timeout port, and PRIME/ACCUM wait indefinitely.

Test Plan:
- Single-shot: N=4, L=2, go; strobes every 3 cycles -> 2 strobes with acc_en=0, then exactly 4 acc_en pulses. result_valid 1 cycle after the 4th. result_ready=1 -> IDLE, ddc_out_enable=0, busy=0.
- Clamping: write L=0 -> lag=1; write L=20 with DELAY=8 -> lag=8. Write N=0 -> one accumulated strobe per window.
- Continuous with late readout: N=3, continuous=1; hold result_ready low 10 cycles with strobes every 2 cycles -> 5 strobes dropped, overrun=1. After ready, acc_clr pulses and the next window accumulates 3 fresh strobes with no re-prime.
- Abort in ACCUM after 2 of 5 strobes -> IDLE next cycle, acc_clr=1, result_valid never asserts. A following go runs PRIME again.
- rst asserted in DUMP with result_valid=1 -> all outputs at reset values next cycle. go while busy causes no state change.
- With AUTOC_CTRL_TIMEOUT_EN: go and no strobes -> timeout=1 and IDLE after 65535 idle cycles. A strobe at cycle 65534 restarts the count.
